// File: rtl/mult_div_unit_if.sv
// Handshake/data bundle between the multi-cycle controller and mult_div_unit.
// master: controller side (drives start/op/operands/MTHI/MTLO); slave: the unit.
interface mult_div_unit_if #(
  parameter int N = 32
);
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] opA;
  logic [N-1:0] opB;
  logic         hi_wr;
  logic         lo_wr;
  logic [N-1:0] wr_data;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [N-1:0] hi;
  logic [N-1:0] lo;

  modport master (
    output start, op, opA, opB,
    output hi_wr, lo_wr, wr_data,
    input  busy, done, div_by_zero,
    input  hi, lo
  );

  modport slave (
    input  start, op, opA, opB,
    input  hi_wr, lo_wr, wr_data,
    output busy, done, div_by_zero,
    output hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit, one result bit per cycle, HI/LO pair.
// Ports: clk, rst (async high), bus (slave: start/op/opA/opB, MTHI/MTLO, busy/done/dbz, hi/lo).
module mult_div_unit #(
  parameter int N = 32
) (
  input  logic             clk,
  input  logic             rst,
  mult_div_unit_if.slave   bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        r_state;
  logic          r_div;
  logic          r_neg;
  logic          r_rneg;
  logic          r_dz;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_a_raw;
  logic [N-1:0]  r_ph;
  logic [N-1:0]  r_pl;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_hi;
  logic [N-1:0]  r_lo;
  logic          r_busy;
  logic          r_done;
  logic          r_dbz;

  logic          w_a_neg;
  logic          w_b_neg;
  logic [N-1:0]  w_a_abs;
  logic [N-1:0]  w_b_abs;
  logic [N:0]    w_sum;
  logic [N-1:0]  w_mul_ph;
  logic [N-1:0]  w_mul_pl;
  logic [N:0]    w_shift;
  logic          w_qbit;
  logic [N-1:0]  w_diff;
  logic [N-1:0]  w_div_ph;
  logic [N-1:0]  w_div_pl;
  logic [N-1:0]  w_nph;
  logic [N-1:0]  w_npl;
  logic [2*N-1:0] w_prod;
  logic [2*N-1:0] w_prod_fix;
  logic [N-1:0]  w_q;
  logic [N-1:0]  w_r;
  logic [N-1:0]  w_res_hi;
  logic [N-1:0]  w_res_lo;

  // Magnitudes; signs only matter for MULT/DIV (op[0]).
  assign w_a_neg = bus.op[0] & bus.opA[N-1];
  assign w_b_neg = bus.op[0] & bus.opB[N-1];
  assign w_a_abs = w_a_neg ? -bus.opA : bus.opA;
  assign w_b_abs = w_b_neg ? -bus.opB : bus.opB;

  // Shift-add: r_ph:r_pl is the running product, r_pl
  // starts as the multiplier and drains out to the right.
  assign w_sum    = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_b} : '0);
  assign w_mul_ph = w_sum[N:1];
  assign w_mul_pl = {w_sum[0], r_pl[N-1:1]};

  // Restoring divide: r_ph is the partial remainder,
  // r_pl shifts dividend bits out and quotient bits in.
  assign w_shift  = {r_ph, r_pl[N-1]};
  assign w_qbit   = (w_shift >= {1'b0, r_b});
  // Difference is below r_b when taken, so N bits suffice.
  assign w_diff   = w_shift[N-1:0] - r_b;
  assign w_div_ph = w_qbit ? w_diff : w_shift[N-1:0];
  assign w_div_pl = {r_pl[N-2:0], w_qbit};

  assign w_nph = r_div ? w_div_ph : w_mul_ph;
  assign w_npl = r_div ? w_div_pl : w_mul_pl;

  assign w_prod     = {w_nph, w_npl};
  assign w_prod_fix = r_neg ? -w_prod : w_prod;
  assign w_q        = r_neg ? -w_npl : w_npl;
  assign w_r        = r_rneg ? -w_nph : w_nph;

  // Zero divisor bypasses the datapath result entirely.
  always_comb begin
    w_res_hi = w_prod_fix[2*N-1:N];
    w_res_lo = w_prod_fix[N-1:0];
    if (r_div) begin
      if (r_dz) begin
        w_res_hi = r_a_raw;
        w_res_lo = '1;
      end else begin
        w_res_hi = w_r;
        w_res_lo = w_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_div   <= 1'b0;
      r_neg   <= 1'b0;
      r_rneg  <= 1'b0;
      r_dz    <= 1'b0;
      r_b     <= '0;
      r_a_raw <= '0;
      r_ph    <= '0;
      r_pl    <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      unique case (r_state)
        S_RUN: begin
          r_ph  <= w_nph;
          r_pl  <= w_npl;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(N-1)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_dbz   <= r_dz;
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
          end
        end
        default: begin
          if (bus.hi_wr) r_hi <= bus.wr_data;
          if (bus.lo_wr) r_lo <= bus.wr_data;
          if (bus.start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_div   <= bus.op[1];
            r_neg   <= w_a_neg ^ w_b_neg;
            r_rneg  <= w_a_neg;
            r_dz    <= bus.op[1] & (bus.opB == '0);
            r_b     <= w_b_abs;
            r_a_raw <= bus.opA;
            r_ph    <= '0;
            r_pl    <= w_a_abs;
            r_cnt   <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random ops
// against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [N-1:0] m_hi = '0;
  logic [N-1:0] m_lo = '0;

  mult_div_unit_if #(.N(N)) bus ();

  mult_div_unit #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void model(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] h,
    output logic [31:0] l,
    output logic        dz
  );
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    dz = 1'b0;
    h  = '0;
    l  = '0;
    case (op)
      2'd0: begin
        p = ua * ub;
        h = p[63:32];
        l = p[31:0];
      end
      2'd1: begin
        p = 64'(sa * sb);
        h = p[63:32];
        l = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          dz = 1'b1;
          l  = 32'hFFFF_FFFF;
          h  = a;
        end else if (op == 2'd2) begin
          l = 32'(ua / ub);
          h = 32'(ua % ub);
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000;
          h = 32'd0;
        end else begin
          l = 32'(sa / sb);
          h = 32'(sa % sb);
        end
      end
    endcase
  endfunction

  // Enters at edge+1; leaves at edge+1 of the done cycle.
  // inj >= 0 injects start+MTHI/MTLO while busy.
  task automatic run_op(
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input int          inj,
    input logic        wr_hi,
    input logic [31:0] wdata,
    input string       nm
  );
    logic [31:0] eh;
    logic [31:0] el;
    logic        edz;
    model(op, a, b, eh, el, edz);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opA   = a;
    bus.opB   = b;
    if (wr_hi) begin
      bus.hi_wr   = 1'b1;
      bus.wr_data = wdata;
    end
    @(posedge clk); #1;
    if (wr_hi) m_hi = wdata;
    bus.start = 1'b0;
    bus.hi_wr = 1'b0;
    bus.opA   = $urandom;
    bus.opB   = $urandom;
    for (int i = 0; i < N; i++) begin
      n_tests++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 ||
          bus.hi !== m_hi || bus.lo !== m_lo) begin
        n_fail++;
        $display("FAIL %s run cyc%0d: busy=%b done=%b hi=%h lo=%h, want busy=1 done=0 hi=%h lo=%h",
                 nm, i, bus.busy, bus.done, bus.hi, bus.lo, m_hi, m_lo);
      end
      if (i == inj) begin
        bus.start   = 1'b1;
        bus.op      = 2'($urandom);
        bus.opA     = $urandom;
        bus.opB     = $urandom;
        bus.hi_wr   = 1'b1;
        bus.lo_wr   = 1'b1;
        bus.wr_data = $urandom;
      end else begin
        bus.start = 1'b0;
        bus.hi_wr = 1'b0;
        bus.lo_wr = 1'b0;
      end
      @(posedge clk); #1;
    end
    m_hi = eh;
    m_lo = el;
    n_tests++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.div_by_zero !== edz ||
        bus.hi !== eh || bus.lo !== el) begin
      n_fail++;
      $display("FAIL %s result: done=%b busy=%b dz=%b hi=%h lo=%h, want 1 0 %b hi=%h lo=%h",
               nm, bus.done, bus.busy, bus.div_by_zero, bus.hi, bus.lo, edz, eh, el);
    end
  endtask

  task automatic idle_cycle(input string nm);
    bus.start = 1'b0;
    bus.hi_wr = 1'b0;
    bus.lo_wr = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_by_zero !== 1'b0 ||
        bus.hi !== m_hi || bus.lo !== m_lo) begin
      n_fail++;
      $display("FAIL %s idle: busy=%b done=%b dz=%b hi=%h lo=%h, want 0 0 0 hi=%h lo=%h",
               nm, bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_by_zero !== 1'b0 ||
        bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b dz=%b hi=%h lo=%h, want all zero",
               bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo);
    end
    rst = 1'b0;
    idle_cycle("post_reset");
  endtask

  task automatic test_directed;
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, 0, "multu_max");
    idle_cycle("multu_max");
    run_op(2'd1, 32'hFFFF_FFFD, 32'd5, -1, 1'b0, 0, "mult_neg");
    idle_cycle("mult_neg");
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, 0, "div_neg");
    idle_cycle("div_neg");
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, 0, "div_ovf");
    idle_cycle("div_ovf");
    run_op(2'd2, 32'd7, 32'd0, -1, 1'b0, 0, "divu_zero");
    idle_cycle("divu_zero");
    run_op(2'd3, 32'hFFFF_FF00, 32'd0, -1, 1'b0, 0, "div_zero_neg");
    idle_cycle("div_zero_neg");
  endtask

  task automatic test_ignore_busy;
    run_op(2'd2, 32'd100, 32'd7, 4, 1'b0, 0, "busy_ignore");
    idle_cycle("busy_ignore");
    bus.lo_wr   = 1'b1;
    bus.wr_data = 32'h1234;
    @(posedge clk); #1;
    bus.lo_wr = 1'b0;
    m_lo = 32'h1234;
    n_tests++;
    if (bus.lo !== 32'h1234 || bus.hi !== m_hi) begin
      n_fail++;
      $display("FAIL mtlo: hi=%h lo=%h, want hi=%h lo=00001234", bus.hi, bus.lo, m_hi);
    end
  endtask

  task automatic test_writes;
    run_op(2'd0, 32'd6, 32'd7, -1, 1'b0, 0, "wr_done");
    bus.hi_wr   = 1'b1;
    bus.lo_wr   = 1'b1;
    bus.wr_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.hi_wr = 1'b0;
    bus.lo_wr = 1'b0;
    m_hi = 32'hCAFE_F00D;
    m_lo = 32'hCAFE_F00D;
    n_tests++;
    if (bus.hi !== m_hi || bus.lo !== m_lo || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_in_done: hi=%h lo=%h done=%b, want hi=lo=%h done=0",
               bus.hi, bus.lo, bus.done, m_hi);
    end
    run_op(2'd1, 32'hFFFF_FFF0, 32'd3, -1, 1'b1, 32'h5A5A_0001, "wr_with_start");
    idle_cycle("wr_with_start");
  endtask

  task automatic test_back_to_back;
    run_op(2'd2, 32'd1000, 32'd33, -1, 1'b0, 0, "b2b_first");
    run_op(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, -1, 1'b0, 0, "b2b_second");
    run_op(2'd3, 32'hFFFF_0000, 32'd7, -1, 1'b0, 0, "b2b_third");
    idle_cycle("b2b");
  endtask

  task automatic test_random;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          r;
    for (int k = 0; k < 30; k++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      r  = $urandom_range(0, 9);
      if (r == 0) b = 32'd0;
      if (r == 1) b = 32'($urandom_range(1, 15));
      if (r == 2 && op == 2'd3) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      if (r == 3) a = 32'($urandom_range(0, 100));
      if (r == 4) b = -32'($urandom_range(1, 15));
      run_op(op, a, b, -1, 1'b0, 0, "random");
      if ($urandom_range(0, 1) == 1) idle_cycle("random");
    end
    idle_cycle("random_end");
  endtask

  task automatic test_reset_mid;
    bus.start = 1'b1;
    bus.op    = 2'd1;
    bus.opA   = $urandom;
    bus.opB   = $urandom;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, want all zero",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    m_hi = '0;
    m_lo = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < N + 5; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 ||
          bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_mid after cyc%0d: busy=%b done=%b hi=%h lo=%h, want all zero",
                 i, bus.busy, bus.done, bus.hi, bus.lo);
      end
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.op      = 2'd0;
    bus.opA     = '0;
    bus.opB     = '0;
    bus.hi_wr   = 1'b0;
    bus.lo_wr   = 1'b0;
    bus.wr_data = '0;
    test_reset();
    test_directed();
    test_ignore_busy();
    test_writes();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
